// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
// The control bundle travels as one packed struct so bubbles are a single constant.
package ex_mem_pipe_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef struct packed {
    logic jump;
    logic branch;
    logic branch_ne;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // An invalid EX instruction must not carry any side-effecting control into MEM.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic v);
    return v ? c : CTRL_BUBBLE;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_sat_counter.sv
// Saturating up-counter: increments on inc unless held, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             hold,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !hold && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with stall/flush, branch resolution and a one-shot
// PC redirect that fires once per taken instruction even across long stalls.
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16,
  parameter int BNE_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              jump_i,
  input  logic              branch_i,
  input  logic              branch_ne_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  input  logic              zf_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] read_data2_i,
  input  logic [REG_AW-1:0] write_reg_i,
  input  logic [DATA_W-1:0] next_pc_i,
  input  logic [DATA_W-1:0] branch_target_i,
  input  logic [DATA_W-1:0] jump_target_i,
  output logic              valid_o,
  output logic              jump_o,
  output logic              branch_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o,
  output logic              zf_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] read_data2_o,
  output logic [REG_AW-1:0] write_reg_o,
  output logic [DATA_W-1:0] next_pc_o,
  output logic              redirect_o,
  output logic [DATA_W-1:0] redirect_pc_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic              zf_q, zf_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [REG_AW-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] npc_q, npc_d;
  logic [DATA_W-1:0] btgt_q, btgt_d;
  logic [DATA_W-1:0] jtgt_q, jtgt_d;
  logic              use_ne;
  logic              cond_met;
  logic              taken;

  assign ctrl_in = '{jump:       jump_i,
                     branch:     branch_i,
                     branch_ne:  branch_ne_i,
                     mem_read:   mem_read_i,
                     mem_write:  mem_write_i,
                     mem_to_reg: mem_to_reg_i,
                     reg_write:  reg_write_i};

  assign use_ne     = (BNE_EN != 0) && ctrl_q.branch_ne;
  assign cond_met   = use_ne ? ~zf_q : zf_q;
  assign taken      = valid_q & (ctrl_q.jump | (ctrl_q.branch & cond_met));
  assign redirect_o = taken & ~done_q;
  assign redirect_pc_o = ctrl_q.jump ? jtgt_q : btgt_q;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    zf_d    = zf_q;
    done_d  = done_q;
    alu_d   = alu_q;
    rd2_d   = rd2_q;
    wreg_d  = wreg_q;
    npc_d   = npc_q;
    btgt_d  = btgt_q;
    jtgt_d  = jtgt_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
      zf_d    = 1'b0;
      done_d  = 1'b0;
      alu_d   = '0;
      rd2_d   = '0;
      wreg_d  = '0;
      npc_d   = '0;
      btgt_d  = '0;
      jtgt_d  = '0;
    end else if (stall_i) begin
      // Remember that fetch already saw the redirect for this held instruction.
      done_d = done_q | redirect_o;
    end else begin
      valid_d = valid_i;
      ctrl_d  = gate_ctrl(ctrl_in, valid_i);
      zf_d    = zf_i & valid_i;
      done_d  = 1'b0;
      alu_d   = alu_result_i;
      rd2_d   = read_data2_i;
      wreg_d  = write_reg_i;
      npc_d   = next_pc_i;
      btgt_d  = branch_target_i;
      jtgt_d  = jump_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
      zf_q    <= 1'b0;
      done_q  <= 1'b0;
      alu_q   <= '0;
      rd2_q   <= '0;
      wreg_q  <= '0;
      npc_q   <= '0;
      btgt_q  <= '0;
      jtgt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      zf_q    <= zf_d;
      done_q  <= done_d;
      alu_q   <= alu_d;
      rd2_q   <= rd2_d;
      wreg_q  <= wreg_d;
      npc_q   <= npc_d;
      btgt_q  <= btgt_d;
      jtgt_q  <= jtgt_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (flush_i),
    .hold    (stall_i & ~flush_i),
    .count_o (flush_cnt_o)
  );

  assign valid_o      = valid_q;
  assign jump_o       = ctrl_q.jump;
  assign branch_o     = ctrl_q.branch;
  assign mem_read_o   = ctrl_q.mem_read;
  assign mem_write_o  = ctrl_q.mem_write;
  assign mem_to_reg_o = ctrl_q.mem_to_reg;
  assign reg_write_o  = ctrl_q.reg_write;
  assign zf_o         = zf_q;
  assign alu_result_o = alu_q;
  assign read_data2_o = rd2_q;
  assign write_reg_o  = wreg_q;
  assign next_pc_o    = npc_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of what the MEM stage should be holding.
module tb_ex_mem_pipe_reg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;
  localparam int BNE_EN = 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall_i, flush_i, valid_i, jump_i, branch_i, branch_ne_i;
  logic mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i, zf_i;
  logic [DATA_W-1:0] alu_result_i, read_data2_i, next_pc_i, branch_target_i, jump_target_i;
  logic [REG_AW-1:0] write_reg_i;
  logic valid_o, jump_o, branch_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o, zf_o;
  logic [DATA_W-1:0] alu_result_o, read_data2_o, next_pc_o, redirect_pc_o;
  logic [REG_AW-1:0] write_reg_o;
  logic redirect_o;
  logic [CNT_W-1:0] flush_cnt_o;

  ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W), .BNE_EN(BNE_EN)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .jump_i(jump_i), .branch_i(branch_i), .branch_ne_i(branch_ne_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
    .reg_write_i(reg_write_i), .zf_i(zf_i), .alu_result_i(alu_result_i),
    .read_data2_i(read_data2_i), .write_reg_i(write_reg_i), .next_pc_i(next_pc_i),
    .branch_target_i(branch_target_i), .jump_target_i(jump_target_i),
    .valid_o(valid_o), .jump_o(jump_o), .branch_o(branch_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .zf_o(zf_o), .alu_result_o(alu_result_o), .read_data2_o(read_data2_o),
    .write_reg_o(write_reg_o), .next_pc_o(next_pc_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .flush_cnt_o(flush_cnt_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int redir_seen = 0;

  // Model of the instruction currently sitting in MEM.
  logic m_valid, m_jump, m_branch, m_ne, m_mr, m_mw, m_m2r, m_rw, m_zf, m_fired;
  logic [DATA_W-1:0] m_alu, m_rd2, m_npc, m_bt, m_jt;
  logic [REG_AW-1:0] m_wr;
  int m_flushes;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic model_taken();
    logic cond;
    cond = (BNE_EN != 0 && m_ne) ? !m_zf : m_zf;
    return m_valid && (m_jump || (m_branch && cond));
  endfunction

  task automatic model_clear();
    {m_valid, m_jump, m_branch, m_ne, m_mr, m_mw, m_m2r, m_rw, m_zf, m_fired} = '0;
    m_alu = '0; m_rd2 = '0; m_npc = '0; m_bt = '0; m_jt = '0; m_wr = '0;
  endtask

  task automatic zero_inputs();
    {stall_i, flush_i, valid_i, jump_i, branch_i, branch_ne_i} = '0;
    {mem_read_i, mem_write_i, mem_to_reg_i, reg_write_i, zf_i} = '0;
    alu_result_i = '0; read_data2_i = '0; next_pc_i = '0;
    branch_target_i = '0; jump_target_i = '0; write_reg_i = '0;
  endtask

  task automatic random_payload();
    valid_i = ($urandom_range(0, 9) < 8);
    jump_i = ($urandom_range(0, 5) == 0);
    branch_i = $urandom_range(0, 1);
    branch_ne_i = $urandom_range(0, 1);
    mem_read_i = $urandom_range(0, 1);
    mem_write_i = $urandom_range(0, 1);
    mem_to_reg_i = $urandom_range(0, 1);
    reg_write_i = $urandom_range(0, 1);
    zf_i = $urandom_range(0, 1);
    alu_result_i = $urandom; read_data2_i = $urandom; next_pc_i = $urandom;
    branch_target_i = $urandom; jump_target_i = $urandom;
    write_reg_i = REG_AW'($urandom);
  endtask

  task automatic check_all();
    int exp_cnt;
    exp_cnt = (m_flushes > CNT_MAX) ? CNT_MAX : m_flushes;
    check_eq("valid", 64'(valid_o), 64'(m_valid));
    check_eq("ctrl", 64'({jump_o, branch_o, mem_read_o, mem_write_o, mem_to_reg_o, reg_write_o, zf_o}),
             64'({m_jump, m_branch, m_mr, m_mw, m_m2r, m_rw, m_zf}));
    check_eq("alu_result", 64'(alu_result_o), 64'(m_alu));
    check_eq("read_data2", 64'(read_data2_o), 64'(m_rd2));
    check_eq("write_reg", 64'(write_reg_o), 64'(m_wr));
    check_eq("next_pc", 64'(next_pc_o), 64'(m_npc));
    check_eq("redirect", 64'(redirect_o), 64'(model_taken() && !m_fired));
    check_eq("redirect_pc", 64'(redirect_pc_o), 64'(m_jump ? m_jt : m_bt));
    check_eq("flush_cnt", 64'(flush_cnt_o), 64'(exp_cnt));
  endtask

  // One clock: advance the model from the current inputs, then sample mid-cycle.
  task automatic cycle();
    logic redir_now;
    redir_now = model_taken() && !m_fired;
    if (rst) begin
      model_clear();
      m_flushes = 0;
    end else if (flush_i) begin
      model_clear();
      m_flushes++;
    end else if (stall_i) begin
      m_fired = m_fired || redir_now;
    end else begin
      m_valid = valid_i;
      m_jump = jump_i && valid_i;   m_branch = branch_i && valid_i;
      m_ne = branch_ne_i && valid_i; m_mr = mem_read_i && valid_i;
      m_mw = mem_write_i && valid_i; m_m2r = mem_to_reg_i && valid_i;
      m_rw = reg_write_i && valid_i; m_zf = zf_i && valid_i;
      m_alu = alu_result_i; m_rd2 = read_data2_i; m_wr = write_reg_i;
      m_npc = next_pc_i; m_bt = branch_target_i; m_jt = jump_target_i;
      m_fired = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_all();
    if (redirect_o) redir_seen++;
    $display("cyc %0d rst=%0b fl=%0b st=%0b vin=%0b | valid=%0b redir=%0b pc=%08h cnt=%0d",
             cyc, rst, flush_i, stall_i, valid_i, valid_o, redirect_o, redirect_pc_o, flush_cnt_o);
  endtask

  initial begin
    model_clear();
    m_flushes = 0;
    zero_inputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset held two cycles with garbage on every input.
    repeat (2) begin
      random_payload();
      stall_i = $urandom_range(0, 1);
      flush_i = $urandom_range(0, 1);
      cycle();
    end
    rst = 1'b0;

    // Plain load.
    zero_inputs();
    alu_result_i = 32'h0000_1234; write_reg_i = 5; reg_write_i = 1'b1; valid_i = 1'b1;
    cycle();
    check_eq("load_alu", 64'(alu_result_o), 64'h1234);

    // Taken BEQ held for three stall cycles: one redirect pulse only.
    zero_inputs();
    valid_i = 1'b1; branch_i = 1'b1; zf_i = 1'b1; branch_target_i = 32'h40;
    redir_seen = 0;
    cycle();
    check_eq("beq_pc", 64'(redirect_pc_o), 64'h40);
    stall_i = 1'b1;
    repeat (3) cycle();
    stall_i = 1'b0; valid_i = 1'b0;
    cycle();
    check_eq("redir_once", 64'(redir_seen), 64'd1);

    // BNE polarity.
    zero_inputs();
    valid_i = 1'b1; branch_i = 1'b1; branch_ne_i = 1'b1; zf_i = 1'b1; branch_target_i = 32'h80;
    cycle();
    check_eq("bne_zf1", 64'(redirect_o), 64'd0);
    zf_i = 1'b0;
    cycle();
    check_eq("bne_zf0", 64'(redirect_o), 64'd1);

    // Flush beats stall.
    zero_inputs();
    valid_i = 1'b1; mem_write_i = 1'b1; cycle();
    flush_i = 1'b1; stall_i = 1'b1; cycle();
    check_eq("flush_mw", 64'(mem_write_o), 64'd0);

    // Saturation, then an invalid load that must not count.
    zero_inputs();
    flush_i = 1'b1;
    repeat (5) cycle();
    check_eq("sat_cnt", 64'(flush_cnt_o), 64'(CNT_MAX));
    flush_i = 1'b0; valid_i = 1'b0; mem_read_i = 1'b1; reg_write_i = 1'b1;
    cycle();
    check_eq("bubble_cnt", 64'(flush_cnt_o), 64'(CNT_MAX));

    // Random traffic, including occasional mid-stall resets.
    rst = 1'b1; zero_inputs(); cycle(); rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      random_payload();
      stall_i = ($urandom_range(0, 9) < 3);
      flush_i = ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
